// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one 256x32 dual-port SRAM macro between NUM_REQ
// requesters. Writes are arbitrated round-robin onto port0 and reads
// round-robin onto port1, so one write and one read can issue per cycle.
// Read data returns with a one-hot rsp_valid naming the issuing requester.
// Optional build macro BRAM_ARB_RSP_REG_EN registers the read response,
// which raises read latency from 1 to 2 cycles.
module bram_port_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             csb0,
   output logic                             web0,
   output logic [NUM_WMASKS-1:0]            wmask0,
   output logic [ADDR_WIDTH-1:0]            addr0,
   output logic [DATA_WIDTH-1:0]            din0,
   output logic                             csb1,
   output logic [ADDR_WIDTH-1:0]            addr1,
   input  logic [DATA_WIDTH-1:0]            dout1
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               wr_gnt;
   logic               rd_gnt;
   logic [PTR_W-1:0]   wr_win;
   logic [PTR_W-1:0]   rd_win;
   logic [NUM_REQ-1:0] rd_onehot;

   // Round-robin winner search for both ports, plus the same-address stall
   // that keeps a read from racing a write to the word being written.
   always_comb begin
      logic [PTR_W-1:0] idx;
      // NOTE: every variable assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
      wr_win = '0;
      rd_win = '0;
      idx    = '0;
      if (rst_n) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(wr_ptr) + k) % NUM_REQ);
            if (!wr_gnt && req_valid[idx] && req_we[idx]) begin
               wr_gnt = 1'b1;
               wr_win = idx;
            end
         end
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rd_ptr) + k) % NUM_REQ);
            if (!rd_gnt && req_valid[idx] && !req_we[idx]) begin
               rd_gnt = 1'b1;
               rd_win = idx;
            end
         end
         // The write wins a same-address clash; the read retries next cycle
         // and then sees the freshly written word.
         if (wr_gnt && rd_gnt &&
             (req_addr[int'(rd_win)*ADDR_WIDTH +: ADDR_WIDTH] ==
              req_addr[int'(wr_win)*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd_gnt = 1'b0;
         end
      end
   end

   // Drive the macro ports and the handshake from the grants.
   always_comb begin
      req_ready = '0;
      rd_onehot = '0;
      csb0      = 1'b1;
      web0      = 1'b1;
      wmask0    = '0;
      addr0     = '0;
      din0      = '0;
      csb1      = 1'b1;
      addr1     = '0;
      if (wr_gnt) begin
         req_ready[wr_win] = 1'b1;
         csb0   = 1'b0;
         web0   = 1'b0;
         addr0  = req_addr[int'(wr_win)*ADDR_WIDTH +: ADDR_WIDTH];
         din0   = req_wdata[int'(wr_win)*DATA_WIDTH +: DATA_WIDTH];
         wmask0 = req_wmask[int'(wr_win)*NUM_WMASKS +: NUM_WMASKS];
      end
      if (rd_gnt) begin
         req_ready[rd_win] = 1'b1;
         rd_onehot[rd_win] = 1'b1;
         csb1  = 1'b0;
         addr1 = req_addr[int'(rd_win)*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Advance each pointer past its winner only when that port granted.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_gnt) begin
            wr_ptr <= (wr_win == PTR_W'(NUM_REQ - 1)) ? '0 : wr_win + 1'b1;
         end
         if (rd_gnt) begin
            rd_ptr <= (rd_win == PTR_W'(NUM_REQ - 1)) ? '0 : rd_win + 1'b1;
         end
      end
   end

`ifdef BRAM_ARB_RSP_REG_EN
   logic [NUM_REQ-1:0]    rsp_valid_s1;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   // Two-stage response: valid follows the macro's output stage, data is
   // captured from dout1 one edge after the macro drives it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_s1 <= '0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
      end else begin
         rsp_valid_s1 <= rd_onehot;
         rsp_valid_q  <= rsp_valid_s1;
         if (|rsp_valid_s1) begin
            rsp_rdata_q <= dout1;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`else
   logic [NUM_REQ-1:0] rsp_valid_q;

   // One-cycle response: valid tags the previous cycle's read winner while
   // the macro's dout1 passes straight through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
      end else begin
         rsp_valid_q <= rd_onehot;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = (|rsp_valid_q) ? dout1 : '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed table, reset-mid-read sequence
// and randomized traffic against a behavioural model of the shared SRAM.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

   localparam int NUM_REQ = 2;
   localparam int AW      = 8;
   localparam int DW      = 32;
   localparam int NW      = 4;
`ifdef BRAM_ARB_RSP_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  we;
      logic [7:0]  a0;
      logic [7:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [3:0]  m0;
      logic [3:0]  m1;
      logic [1:0]  rdy;
      logic        csb0;
      logic        csb1;
      logic [1:0]  rv;
      logic [31:0] rd;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_we;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*DW-1:0] req_wdata;
   logic [NUM_REQ*NW-1:0] req_wmask;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [DW-1:0]         rsp_rdata;
   logic                  csb0, web0, csb1;
   logic [NW-1:0]         wmask0;
   logic [AW-1:0]         addr0, addr1;
   logic [DW-1:0]         din0;
   logic [DW-1:0]         dout1 = '0;

   logic [NUM_REQ-1:0]    drv_v = '0;
   logic [NUM_REQ-1:0]    drv_we = '0;
   logic [AW-1:0]         drv_a [NUM_REQ];
   logic [DW-1:0]         drv_d [NUM_REQ];
   logic [NW-1:0]         drv_m [NUM_REQ];

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   int                 m_wptr, m_rptr;
   logic [DW-1:0]      m_mem [256];
   logic [NUM_REQ-1:0] mv [LAT];
   logic [DW-1:0]      md [LAT];
   logic [1:0]         tv [LAT];
   logic [DW-1:0]      td [LAT];
   logic [1:0]         last_ready;

   // SRAM macro model
   logic [DW-1:0] sram [256] = '{default: '0};
   logic [AW-1:0] sram_raddr = '0;

   bram_port_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .csb1(csb1), .addr1(addr1), .dout1(dout1)
   );

   always #5 clk = ~clk;

   // Flatten per-requester drive variables onto the DUT buses.
   always_comb begin
      req_valid = drv_v;
      req_we    = drv_we;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*AW +: AW]  = drv_a[i];
         req_wdata[i*DW +: DW] = drv_d[i];
         req_wmask[i*NW +: NW] = drv_m[i];
      end
   end

   // Macro port0 writes and port1 address capture at posedge.
   always @(posedge clk) begin
      if (!csb0 && !web0) begin
         for (int b = 0; b < NW; b++) begin
            if (wmask0[b]) sram[addr0][b*8 +: 8] <= din0[b*8 +: 8];
         end
      end
      if (!csb1) sram_raddr <= addr1;
   end

   // Macro port1 drives read data after negedge.
   always @(negedge clk) dout1 <= sram[sram_raddr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NUM_REQ-1:0] cand, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (cand[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_wptr = 0;
      m_rptr = 0;
      for (int s = 0; s < LAT; s++) begin
         mv[s] = '0; md[s] = '0; tv[s] = '0; td[s] = '0;
      end
   endtask

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] m0, input logic [3:0] m1,
                               input logic [1:0] rdy, input logic c0, input logic c1,
                               input logic [1:0] rv, input logic [31:0] rd);
      vec_t t;
      t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
      t.m0 = m0; t.m1 = m1; t.rdy = rdy; t.csb0 = c0; t.csb1 = c1;
      t.rv = rv; t.rd = rd;
      return t;
   endfunction

   task automatic apply_row(input vec_t t);
      drv_v  = t.v;
      drv_we = t.we;
      drv_a[0] = t.a0; drv_a[1] = t.a1;
      drv_d[0] = t.d0; drv_d[1] = t.d1;
      drv_m[0] = t.m0; drv_m[1] = t.m1;
   endtask

   // One clock: sample/compare mid-cycle, advance the model, return at posedge+1.
   task automatic cycle(input string pfx, input bit use_tab, input vec_t t,
                        output logic [1:0] granted);
      int w, r;
      logic [1:0] exp_rdy;
      logic [1:0] r_hot;
      @(negedge clk);
      #1;
      w = pick(drv_v & drv_we, m_wptr);
      r = pick(drv_v & ~drv_we, m_rptr);
      if (w >= 0 && r >= 0 && drv_a[r] == drv_a[w]) r = -1;
      exp_rdy = '0;
      r_hot   = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (r >= 0) begin
         exp_rdy[r] = 1'b1;
         r_hot[r]   = 1'b1;
      end
      last_ready = req_ready;
      check({pfx, "_ready"}, req_ready, exp_rdy);
      check({pfx, "_csb0"}, csb0, (w < 0));
      check({pfx, "_web0"}, web0, (w < 0));
      if (w >= 0) begin
         check({pfx, "_addr0"}, addr0, drv_a[w]);
         check({pfx, "_din0"}, din0, drv_d[w]);
         check({pfx, "_wmask0"}, wmask0, drv_m[w]);
      end
      check({pfx, "_csb1"}, csb1, (r < 0));
      if (r >= 0) check({pfx, "_addr1"}, addr1, drv_a[r]);
      check({pfx, "_rsp_valid"}, rsp_valid, mv[LAT-1]);
      if (mv[LAT-1] != '0) check({pfx, "_rsp_rdata"}, rsp_rdata, md[LAT-1]);
      if (use_tab) begin
         check({pfx, "_tab_ready"}, req_ready, t.rdy);
         check({pfx, "_tab_csb0"}, csb0, t.csb0);
         check({pfx, "_tab_csb1"}, csb1, t.csb1);
         check({pfx, "_tab_rsp_valid"}, rsp_valid, tv[LAT-1]);
         if (tv[LAT-1] != '0) check({pfx, "_tab_rsp_rdata"}, rsp_rdata, td[LAT-1]);
      end
      for (int s = LAT - 1; s > 0; s--) begin
         mv[s] = mv[s-1]; md[s] = md[s-1]; tv[s] = tv[s-1]; td[s] = td[s-1];
      end
      mv[0] = r_hot;
      md[0] = (r >= 0) ? m_mem[drv_a[r]] : '0;
      tv[0] = use_tab ? t.rv : '0;
      td[0] = use_tab ? t.rd : '0;
      if (w >= 0) begin
         for (int b = 0; b < NW; b++) begin
            if (drv_m[w][b]) m_mem[drv_a[w]][b*8 +: 8] = drv_d[w][b*8 +: 8];
         end
         m_wptr = (w + 1) % NUM_REQ;
      end
      if (r >= 0) m_rptr = (r + 1) % NUM_REQ;
      granted = exp_rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      @(negedge clk);
      #1;
      check({pfx, "_ready"}, req_ready, 2'b00);
      check({pfx, "_rsp_valid"}, rsp_valid, 2'b00);
      check({pfx, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({pfx, "_csb0"}, csb0, 1'b1);
      check({pfx, "_web0"}, web0, 1'b1);
      check({pfx, "_csb1"}, csb1, 1'b1);
      check({pfx, "_addr0"}, addr0, 8'h0);
      check({pfx, "_din0"}, din0, 32'h0);
      check({pfx, "_wmask0"}, wmask0, 4'h0);
      check({pfx, "_addr1"}, addr1, 8'h0);
   endtask

   vec_t tab [23];
   vec_t blank;

   initial begin
      logic [1:0] g;
      logic [NUM_REQ-1:0] pend;

      blank = mk(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h0);
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
      apply_row(blank);
      model_reset();

      //              v      we     a0     a1     d0            d1            m0    m1       rdy    c0    c1    rv     rd
      tab[0]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        4'h0, 4'h0,    2'b00, 1'b1, 1'b1, 2'b00, 32'h0);
      tab[1]  = mk(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0,        4'hF, 4'h0,    2'b01, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[2]  = mk(2'b10, 2'b00, 8'h00, 8'h10, 32'h0,        32'h0,        4'h0, 4'h0,    2'b10, 1'b1, 1'b0, 2'b10, 32'hDEADBEEF);
      tab[3]  = mk(2'b01, 2'b01, 8'h21, 8'h00, 32'h12345678, 32'h0,        4'hF, 4'h0,    2'b01, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[4]  = mk(2'b11, 2'b01, 8'h20, 8'h21, 32'hCAFEF00D, 32'h0,        4'hF, 4'h0,    2'b11, 1'b0, 1'b0, 2'b10, 32'h12345678);
      tab[5]  = mk(2'b11, 2'b01, 8'h30, 8'h30, 32'hA5A5A5A5, 32'h0,        4'hF, 4'h0,    2'b01, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[6]  = mk(2'b10, 2'b00, 8'h00, 8'h30, 32'h0,        32'h0,        4'h0, 4'h0,    2'b10, 1'b1, 1'b0, 2'b10, 32'hA5A5A5A5);
      tab[7]  = mk(2'b01, 2'b01, 8'h40, 8'h00, 32'h11223344, 32'h0,        4'hF, 4'h0,    2'b01, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[8]  = mk(2'b10, 2'b10, 8'h00, 8'h40, 32'h0,        32'hFFFFFFFF, 4'h0, 4'b0100, 2'b10, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[9]  = mk(2'b01, 2'b00, 8'h40, 8'h00, 32'h0,        32'h0,        4'h0, 4'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'h11FF3344);
      tab[10] = mk(2'b10, 2'b10, 8'h00, 8'h40, 32'h0,        32'h0,        4'h0, 4'h0,    2'b10, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[11] = mk(2'b01, 2'b00, 8'h40, 8'h00, 32'h0,        32'h0,        4'h0, 4'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'h11FF3344);
      for (int i = 0; i < 6; i++)
         tab[12+i] = mk(2'b11, 2'b11, 8'h50, 8'h51, 32'h1, 32'h2, 4'hF, 4'hF,
                        (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b1, 2'b00, 32'h0);
      tab[18] = mk(2'b11, 2'b00, 8'h10, 8'h21, 32'h0,        32'h0,        4'h0, 4'h0,    2'b10, 1'b1, 1'b0, 2'b10, 32'h12345678);
      tab[19] = mk(2'b11, 2'b00, 8'h10, 8'h40, 32'h0,        32'h0,        4'h0, 4'h0,    2'b01, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF);
      tab[20] = mk(2'b10, 2'b00, 8'h10, 8'h40, 32'h0,        32'h0,        4'h0, 4'h0,    2'b10, 1'b1, 1'b0, 2'b10, 32'h11FF3344);
      tab[21] = blank;
      tab[22] = blank;

      // Power-on reset
      repeat (2) @(posedge clk);
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 23; i++) begin
         apply_row(tab[i]);
         cycle($sformatf("row%0d", i), 1'b1, tab[i], g);
      end

      // Reset asserted the cycle after a read is accepted
      apply_row(mk(2'b10, 2'b00, 8'h00, 8'h21, 32'h0, 32'h0, 4'h0, 4'h0,
                   2'b00, 1'b1, 1'b1, 2'b00, 32'h0));
      cycle("rst_rd", 1'b0, blank, g);
      rst_n = 1'b0;
      apply_row(mk(2'b11, 2'b11, 8'h60, 8'h61, 32'h77, 32'h88, 4'hF, 4'hF,
                   2'b00, 1'b1, 1'b1, 2'b00, 32'h0));
      model_reset();
      check_reset_outputs("in_rst0");
      check_reset_outputs("in_rst1");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply_row(blank);
      for (int i = 0; i < 3; i++) cycle($sformatf("post_rst%0d", i), 1'b0, blank, g);
      apply_row(mk(2'b11, 2'b11, 8'h60, 8'h61, 32'h77, 32'h88, 4'hF, 4'hF,
                   2'b00, 1'b1, 1'b1, 2'b00, 32'h0));
      cycle("post_rst_wr", 1'b0, blank, g);
      check("post_rst_wr_first", last_ready, 2'b01);
      apply_row(mk(2'b11, 2'b00, 8'h60, 8'h61, 32'h0, 32'h0, 4'h0, 4'h0,
                   2'b00, 1'b1, 1'b1, 2'b00, 32'h0));
      cycle("post_rst_rd", 1'b0, blank, g);
      check("post_rst_rd_first", last_ready, 2'b01);
      apply_row(blank);
      for (int i = 0; i < LAT + 1; i++) cycle($sformatf("drain%0d", i), 1'b0, blank, g);

      // Randomized traffic with hold-until-accepted requesters
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 7) begin
               pend[i]   = 1'b1;
               drv_we[i] = 1'($urandom_range(0, 1));
               drv_a[i]  = 8'($urandom_range(0, 7));
               drv_d[i]  = $urandom;
               drv_m[i]  = 4'($urandom_range(0, 15));
            end
            drv_v[i] = pend[i];
         end
         cycle("rnd", 1'b0, blank, g);
         pend = pend & ~g;
      end
      apply_row(blank);
      for (int i = 0; i < LAT + 1; i++) cycle("rnd_drain", 1'b0, blank, g);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one 256x32 dual-port SRAM macro (port0 read/write, used for writes only; port1 read-only) between NUM_REQ fabric-side requesters.
- Each requester issues read or write ops over a valid/ready handshake.
- Writes are arbitrated round-robin onto port0 and reads round-robin onto port1, so one write and one read can be issued per cycle.
- Read data returns to the issuing requester with a fixed latency, tagged by a one-hot response valid.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_WIDTH, 8, SRAM word address width
- DATA_WIDTH, 32, SRAM word width
- NUM_WMASKS, 4, byte write-mask bits (DATA_WIDTH/8)

Ports:
- clk  in  1  clock; also drives clk0/clk1 of the macro externally
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester op valid
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened word addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_wmask  in  NUM_REQ*NUM_WMASKS  flattened byte masks, active-high
- req_ready  out  NUM_REQ  op accepted this cycle
- rsp_valid  out  NUM_REQ  one-hot, read data valid for requester i
- rsp_rdata  out  DATA_WIDTH  shared read data
- csb0  out  1  port0 chip select, active-low
- web0  out  1  port0 write enable, active-low
- wmask0  out  NUM_WMASKS  port0 byte mask
- addr0  out  ADDR_WIDTH  port0 address
- din0  out  DATA_WIDTH  port0 write data
- csb1  out  1  port1 chip select, active-low
- addr1  out  ADDR_WIDTH  port1 address
- dout1  in  DATA_WIDTH  port1 read data from macro

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0.
  - rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
  - csb0 = web0 = csb1 = 1.
  - wmask0/addr0/din0/addr1 = 0.
  - Reset mid-operation drops any in-flight read response; no rsp_valid is produced after release for ops issued before reset.
- Write arbitration (combinational from registered wr_ptr):
  - Candidates are requesters with req_valid & req_we.
  - Winner is the first candidate found scanning from wr_ptr upward, with wrap.
  - Winner drives addr0/din0/wmask0 with csb0 = web0 = 0, and gets req_ready = 1.
  - No candidate: csb0 = web0 = 1.
  - On a grant, wr_ptr <= (winner+1) mod NUM_REQ at posedge; otherwise wr_ptr holds.
- Read arbitration: identical scheme with rd_ptr, candidates req_valid & !req_we; winner drives addr1 with csb1 = 0.
- Collision rule:
  - If the read winner's address equals the granted write address in the same cycle, the read is stalled: csb1 = 1, read winner's req_ready = 0, rd_ptr holds.
  - Write proceeds; the read re-arbitrates next cycle and returns the new data.
- A requester never gets both grants in one cycle (one op per requester per cycle).
- req_ready is combinational. An op completes when req_valid & req_ready at posedge. Requesters hold req_* stable while valid and not ready.
- Read latency is 1 cycle:
  - Macro registers addr1 at posedge N and drives dout1 after negedge N.
  - Cycle N+1: rsp_valid = one-hot of the cycle-N read winner (registered), rsp_rdata = dout1 (pass-through).
  - rsp_rdata is don't-care when rsp_valid = 0; back-to-back reads give rsp_valid every cycle.
- Writes produce no response; data is visible to a read accepted on the next cycle or later.
- Zero-mask write (wmask = 0) is still granted and consumes a slot; memory is unchanged.

Optional Feature:
- Macro BRAM_ARB_RSP_REG_EN.
- Defined:
  - rsp_rdata is registered from dout1, and rsp_valid is delayed one more stage; read latency is 2 cycles.
  - Both response stages reset to 0; throughput is unchanged.
- Undefined: 1-cycle latency with combinational rsp_rdata as above.

Test Plan:
- Reset then single write: req0 write addr 0x10, data 0xDEADBEEF, mask 4'hF → req_ready[0] same cycle, csb0 = web0 = 0, addr0 = 0x10. Then req1 read 0x10 → rsp_valid = 2'b10 one cycle later (two with BRAM_ARB_RSP_REG_EN), rsp_rdata = 0xDEADBEEF.
- Contention fairness: req0 and req1 both write continuously for 6 cycles → grants alternate 0,1,0,1,0,1; no starvation.
- Parallel ports: req0 writes 0x20 while req1 reads 0x21 (pre-loaded 0x12345678) → both ready in the same cycle; rsp_rdata = 0x12345678 to req1.
- Collision: req0 writes 0x30 = 0xA5A5A5A5 while req1 reads 0x30 → req_ready = 2'b01. Next cycle req1 is granted; response reads 0xA5A5A5A5.
- Byte mask: word 0x40 = 0x11223344, then write 0xFFFFFFFF with mask 4'b0100 → read returns 0x11FF3344.
- Reset mid-read: assert rst_n low in the cycle after a read is accepted → rsp_valid stays 0 through and after reset; wr_ptr/rd_ptr back to 0 (req0 wins the first contended grant).
